vx_lsu_mem_bridge: RTL and testbench



---
 rtl/vx_lsu_mem_bridge.sv | 231 +++++++++++++++++++++++
 tb/tb_vx_lsu_mem_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_lsu_mem_bridge.sv
// vx_lsu_mem_bridge
// Terminates one multi-lane LSU request at a time and serializes its active
// lanes into single-word memory beats, lowest lane first, tagged with the lane
// index. Read words may come back in any order; they are scattered into
// per-lane slots and returned as a single LSU response.
//
// Optional feature: define LSU_BRIDGE_WR_ACK_EN to have writes produce a
// zero-data LSU response after their last beat. Left undefined, writes
// complete silently and return straight to IDLE.
//
// state | meaning
// IDLE  | ready for a new LSU request
// ISSUE | sending one memory beat per active lane, collecting early read data
// WAIT  | all beats sent, waiting for outstanding read words
// RESP  | presenting the gathered LSU response until accepted

module vx_lsu_mem_bridge #(
    parameter int NUM_LANES  = 4,
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 8,
    parameter int WORD_W     = 8 * WORD_SIZE,
    parameter int LANE_BITS  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,

    input  logic                              lsu_req_valid_i,
    output logic                              lsu_req_ready_o,
    input  logic                              lsu_req_rw_i,
    input  logic [NUM_LANES-1:0]              lsu_req_mask_i,
    input  logic [NUM_LANES*WORD_SIZE-1:0]    lsu_req_byteen_i,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]   lsu_req_addr_i,
    input  logic [NUM_LANES*WORD_W-1:0]       lsu_req_data_i,
    input  logic [TAG_WIDTH-1:0]              lsu_req_tag_i,

    output logic                              lsu_rsp_valid_o,
    input  logic                              lsu_rsp_ready_i,
    output logic [NUM_LANES-1:0]              lsu_rsp_mask_o,
    output logic [NUM_LANES*WORD_W-1:0]       lsu_rsp_data_o,
    output logic [TAG_WIDTH-1:0]              lsu_rsp_tag_o,

    output logic                              mem_req_valid_o,
    input  logic                              mem_req_ready_i,
    output logic                              mem_req_rw_o,
    output logic [ADDR_WIDTH-1:0]             mem_req_addr_o,
    output logic [WORD_SIZE-1:0]              mem_req_byteen_o,
    output logic [WORD_W-1:0]                 mem_req_data_o,
    output logic [LANE_BITS-1:0]              mem_req_tag_o,

    input  logic                              mem_rsp_valid_i,
    output logic                              mem_rsp_ready_o,
    input  logic [WORD_W-1:0]                 mem_rsp_data_i,
    input  logic [LANE_BITS-1:0]              mem_rsp_tag_i
);

    localparam int CNT_W = $clog2(NUM_LANES + 1);

`ifdef LSU_BRIDGE_WR_ACK_EN
    localparam logic WR_ACK = 1'b1;
`else
    localparam logic WR_ACK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                            state_q;
    logic                              rw_q;
    logic [NUM_LANES-1:0]              mask_q;
    logic [NUM_LANES*WORD_SIZE-1:0]    byteen_q;
    logic [NUM_LANES*ADDR_WIDTH-1:0]   addr_q;
    logic [NUM_LANES*WORD_W-1:0]       wdata_q;
    logic [TAG_WIDTH-1:0]              tag_q;
    logic [NUM_LANES-1:0]              todo_q, todo_d;
    logic [NUM_LANES-1:0]              outst_q, outst_d;
    logic [CNT_W-1:0]                  pending_q, pending_d;
    logic [WORD_W-1:0]                 slot_q [NUM_LANES];

    logic                              mreq_valid_q;
    logic                              mreq_rw_q;
    logic [ADDR_WIDTH-1:0]             mreq_addr_q;
    logic [WORD_SIZE-1:0]              mreq_byteen_q;
    logic [WORD_W-1:0]                 mreq_data_q;
    logic [LANE_BITS-1:0]              mreq_tag_q;

    logic                              issue_hs, rd_issue, rsp_hs, rsp_ok;
    logic [LANE_BITS-1:0]              nb_lane;
    logic [ADDR_WIDTH-1:0]             nb_addr;
    logic [WORD_SIZE-1:0]              nb_byteen;
    logic [WORD_W-1:0]                 nb_data;

    function automatic logic [LANE_BITS-1:0] low_lane(input logic [NUM_LANES-1:0] m);
        logic [LANE_BITS-1:0] l;
        l = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (m[i]) l = LANE_BITS'(i);
        end
        return l;
    endfunction

    // Handshake decode, bookkeeping next-state and the fields of the next beat
    always_comb begin
        issue_hs = (state_q == ISSUE) && mreq_valid_q && mem_req_ready_i;
        rd_issue = issue_hs && !rw_q;
        rsp_hs   = mem_rsp_valid_i && mem_rsp_ready_o;
        rsp_ok   = rsp_hs && (int'(mem_rsp_tag_i) < NUM_LANES) && outst_q[mem_rsp_tag_i];

        todo_d = todo_q;
        if (issue_hs) todo_d[mreq_tag_q] = 1'b0;

        outst_d = outst_q;
        if (rd_issue) outst_d[mreq_tag_q] = 1'b1;
        if (rsp_ok)   outst_d[mem_rsp_tag_i] = 1'b0;

        pending_d = pending_q;
        if (rd_issue && !rsp_ok)      pending_d = pending_q + 1'b1;
        else if (rsp_ok && !rd_issue) pending_d = pending_q - 1'b1;

        // The first beat comes straight from the request inputs so that it can
        // be presented the cycle after acceptance.
        if (state_q == IDLE) begin
            nb_lane   = low_lane(lsu_req_mask_i);
            nb_addr   = lsu_req_addr_i[int'(nb_lane)*ADDR_WIDTH +: ADDR_WIDTH];
            nb_byteen = lsu_req_byteen_i[int'(nb_lane)*WORD_SIZE +: WORD_SIZE];
            nb_data   = lsu_req_data_i[int'(nb_lane)*WORD_W +: WORD_W];
        end else begin
            nb_lane   = low_lane(todo_d);
            nb_addr   = addr_q[int'(nb_lane)*ADDR_WIDTH +: ADDR_WIDTH];
            nb_byteen = byteen_q[int'(nb_lane)*WORD_SIZE +: WORD_SIZE];
            nb_data   = wdata_q[int'(nb_lane)*WORD_W +: WORD_W];
        end
    end

    // Sequencer: request capture, beat issue, read gather and response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            rw_q          <= 1'b0;
            mask_q        <= '0;
            byteen_q      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            tag_q         <= '0;
            todo_q        <= '0;
            outst_q       <= '0;
            pending_q     <= '0;
            for (int i = 0; i < NUM_LANES; i++) slot_q[i] <= '0;
            mreq_valid_q  <= 1'b0;
            mreq_rw_q     <= 1'b0;
            mreq_addr_q   <= '0;
            mreq_byteen_q <= '0;
            mreq_data_q   <= '0;
            mreq_tag_q    <= '0;
        end else begin
            todo_q    <= todo_d;
            outst_q   <= outst_d;
            pending_q <= pending_d;
            if (rsp_ok) slot_q[mem_rsp_tag_i] <= mem_rsp_data_i;

            case (state_q)
                IDLE: begin
                    if (lsu_req_valid_i) begin
                        rw_q          <= lsu_req_rw_i;
                        mask_q        <= lsu_req_mask_i;
                        byteen_q      <= lsu_req_byteen_i;
                        addr_q        <= lsu_req_addr_i;
                        wdata_q       <= lsu_req_data_i;
                        tag_q         <= lsu_req_tag_i;
                        todo_q        <= lsu_req_mask_i;
                        outst_q       <= '0;
                        pending_q     <= '0;
                        for (int i = 0; i < NUM_LANES; i++) slot_q[i] <= '0;
                        mreq_valid_q  <= |lsu_req_mask_i;
                        mreq_rw_q     <= lsu_req_rw_i;
                        mreq_addr_q   <= nb_addr;
                        mreq_byteen_q <= nb_byteen;
                        mreq_data_q   <= nb_data;
                        mreq_tag_q    <= nb_lane;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_hs) begin
                        mreq_valid_q  <= |todo_d;
                        mreq_addr_q   <= nb_addr;
                        mreq_byteen_q <= nb_byteen;
                        mreq_data_q   <= nb_data;
                        mreq_tag_q    <= nb_lane;
                    end
                    // An empty read still passes through WAIT so that its
                    // response timing matches the regular read path.
                    if (todo_d == '0) begin
                        if (rw_q) state_q <= WR_ACK ? RESP : IDLE;
                        else      state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (pending_q == '0) state_q <= RESP;
                end
                RESP: begin
                    if (lsu_rsp_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state; response fields gated to RESP
    always_comb begin
        lsu_req_ready_o  = (state_q == IDLE);
        mem_rsp_ready_o  = (state_q == ISSUE) || (state_q == WAIT);
        lsu_rsp_valid_o  = (state_q == RESP);
        lsu_rsp_mask_o   = lsu_rsp_valid_o ? mask_q : '0;
        lsu_rsp_tag_o    = lsu_rsp_valid_o ? tag_q : '0;
        lsu_rsp_data_o   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lsu_rsp_data_o[i*WORD_W +: WORD_W] = lsu_rsp_valid_o ? slot_q[i] : '0;
        end
        mem_req_valid_o  = mreq_valid_q;
        mem_req_rw_o     = mreq_rw_q;
        mem_req_addr_o   = mreq_addr_q;
        mem_req_byteen_o = mreq_byteen_q;
        mem_req_data_o   = mreq_data_q;
        mem_req_tag_o    = mreq_tag_q;
    end

    // A memory word for a lane that is not outstanding is a protocol error;
    // the hardware drops it.
    a_rsp_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni) rsp_hs |-> rsp_ok);

endmodule

// File: tb/tb_vx_lsu_mem_bridge.sv
// Directed bench for vx_lsu_mem_bridge: a table of read transactions plus
// hand-written write, backpressure and reset sequences. A small memory
// responder returns 0xD0000000 | addr for every read beat.
module tb_vx_lsu_mem_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         lsu_req_valid, lsu_req_ready, lsu_req_rw;
    logic [3:0]   lsu_req_mask;
    logic [15:0]  lsu_req_byteen;
    logic [119:0] lsu_req_addr;
    logic [127:0] lsu_req_data;
    logic [7:0]   lsu_req_tag;
    logic         lsu_rsp_valid, lsu_rsp_ready;
    logic [3:0]   lsu_rsp_mask;
    logic [127:0] lsu_rsp_data;
    logic [7:0]   lsu_rsp_tag;
    logic         mem_req_valid, mem_req_ready, mem_req_rw;
    logic [29:0]  mem_req_addr;
    logic [3:0]   mem_req_byteen;
    logic [31:0]  mem_req_data;
    logic [1:0]   mem_req_tag;
    logic         mem_rsp_valid, mem_rsp_ready;
    logic [31:0]  mem_rsp_data;
    logic [1:0]   mem_rsp_tag;

    always #5 clk = ~clk;

    vx_lsu_mem_bridge dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready),
        .lsu_req_rw_i(lsu_req_rw), .lsu_req_mask_i(lsu_req_mask),
        .lsu_req_byteen_i(lsu_req_byteen), .lsu_req_addr_i(lsu_req_addr),
        .lsu_req_data_i(lsu_req_data), .lsu_req_tag_i(lsu_req_tag),
        .lsu_rsp_valid_o(lsu_rsp_valid), .lsu_rsp_ready_i(lsu_rsp_ready),
        .lsu_rsp_mask_o(lsu_rsp_mask), .lsu_rsp_data_o(lsu_rsp_data),
        .lsu_rsp_tag_o(lsu_rsp_tag),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_rw_o(mem_req_rw), .mem_req_addr_o(mem_req_addr),
        .mem_req_byteen_o(mem_req_byteen), .mem_req_data_o(mem_req_data),
        .mem_req_tag_o(mem_req_tag),
        .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_ready_o(mem_rsp_ready),
        .mem_rsp_data_i(mem_rsp_data), .mem_rsp_tag_i(mem_rsp_tag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [1:0]  ord_q[$];
    logic [1:0]  beat_tag[$];
    logic [29:0] beat_addr[$];
    logic [3:0]  beat_be[$];
    logic [31:0] beat_data[$];
    logic        beat_rw[$];
    logic [29:0] lane_addr [4];
    int          issued_cnt = 0;
    int          gate = 0;
    bit          stream_mode = 1'b1;
    bit          rdy_mode = 1'b0;
    bit          tog = 1'b0;
    bit          prev_stall = 1'b0;
    logic [69:0] prev_fields;
    int          pmax = 0;
    wire  [69:0] mreq_fields = {mem_req_valid, mem_req_rw, mem_req_tag, mem_req_addr,
                                mem_req_byteen, mem_req_data};

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_rsp_valid = 1'b0;
            prev_stall    = 1'b0;
        end else begin
            if (prev_stall) chk("mreq_stall_hold", 128'(mreq_fields), 128'(prev_fields));
            mem_rsp_valid = 1'b0;
            if (ord_q.size() > 0 && issued_cnt >= gate) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_tag   = ord_q[0];
                mem_rsp_data  = 32'hD000_0000 | {2'b00, lane_addr[ord_q[0]]};
                if (mem_rsp_ready) void'(ord_q.pop_front());
            end
            if (rdy_mode) begin
                tog = ~tog;
                mem_req_ready = tog;
            end else begin
                mem_req_ready = 1'b1;
            end
            if (mem_req_valid && mem_req_ready) begin
                beat_tag.push_back(mem_req_tag);
                beat_addr.push_back(mem_req_addr);
                beat_be.push_back(mem_req_byteen);
                beat_data.push_back(mem_req_data);
                beat_rw.push_back(mem_req_rw);
                lane_addr[mem_req_tag] = mem_req_addr;
                issued_cnt++;
                if (stream_mode && !mem_req_rw) ord_q.push_back(mem_req_tag);
            end
            prev_stall  = mem_req_valid && !mem_req_ready;
            prev_fields = mreq_fields;
            if (int'(dut.pending_q) > pmax) pmax = int'(dut.pending_q);
        end
    end

    task automatic clear_logs();
        ord_q.delete();
        beat_tag.delete(); beat_addr.delete(); beat_be.delete();
        beat_data.delete(); beat_rw.delete();
        issued_cnt = 0;
        pmax = 0;
    endtask

    // ---------------- read vectors ----------------
    typedef struct {
        logic [3:0]   mask;
        logic [7:0]   tag;
        logic [119:0] addr;
        bit           stream;
        logic [7:0]   order;     // response lane order, 2 bits per entry
        int           n_beats;
        logic [7:0]   exp_seq;   // expected issue lane order, 2 bits per beat
        logic [127:0] exp_data;
        int           exp_lat;   // edges from acceptance to lsu_rsp_valid
        int           hold;      // cycles lsu_rsp_ready is held low
        int           exp_pmax;
    } vec_t;

    vec_t vecs [5];

    task automatic do_txn(input vec_t v, input string nm);
        int k;
        @(negedge clk);
        clear_logs();
        stream_mode = v.stream;
        gate = v.stream ? 0 : v.n_beats;
        if (!v.stream) for (int i = 0; i < v.n_beats; i++) ord_q.push_back(v.order[2*i +: 2]);
        lsu_req_valid  = 1'b1;
        lsu_req_rw     = 1'b0;
        lsu_req_mask   = v.mask;
        lsu_req_byteen = 16'h0;
        lsu_req_addr   = v.addr;
        lsu_req_data   = '0;
        lsu_req_tag    = v.tag;
        chk({nm, " req_ready"}, 128'(lsu_req_ready), 128'(1));
        @(negedge clk);
        lsu_req_valid = 1'b0;
        k = 0;
        while (!lsu_rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " rsp_latency"}, 128'(k), 128'(v.exp_lat));
        chk({nm, " rsp_data"}, lsu_rsp_data, v.exp_data);
        chk({nm, " rsp_mask_tag"}, 128'({lsu_rsp_mask, lsu_rsp_tag}), 128'({v.mask, v.tag}));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({nm, " hold"}, {lsu_rsp_valid, lsu_req_ready, lsu_rsp_mask, lsu_rsp_tag, lsu_rsp_data[113:0]},
                {1'b1, 1'b0, v.mask, v.tag, v.exp_data[113:0]});
        end
        lsu_rsp_ready = 1'b1;
        @(negedge clk);
        lsu_rsp_ready = 1'b0;
        chk({nm, " back_to_idle"}, 128'({lsu_req_ready, lsu_rsp_valid}), 128'(2'b10));
        chk({nm, " beats"}, 128'(beat_tag.size()), 128'(v.n_beats));
        for (int i = 0; i < beat_tag.size() && i < v.n_beats; i++) begin
            chk($sformatf("%s beat%0d lane", nm, i), 128'(beat_tag[i]), 128'(v.exp_seq[2*i +: 2]));
            chk($sformatf("%s beat%0d addr_rw", nm, i), 128'({beat_rw[i], beat_addr[i]}),
                128'({1'b0, v.addr[30*int'(v.exp_seq[2*i +: 2]) +: 30]}));
        end
        chk({nm, " pending_peak"}, 128'(pmax), 128'(v.exp_pmax));
    endtask

    initial begin
        bit done, saw_rsp;
        int k;
        vec_t v;

        //            mask     tag    addr (lane3..lane0)                          strm order  n  seq    data (lane3..lane0)                                                 lat hold pmax
        vecs[0] = '{4'b1011, 8'h3C, {30'h13, 30'h12, 30'h11, 30'h10},             1'b0, 8'h13, 3, 8'h34, {32'hD000_0013, 32'h0, 32'hD000_0011, 32'hD000_0010},           7, 0, 3};
        vecs[1] = '{4'b0001, 8'hA5, {30'h23, 30'h22, 30'h21, 30'h20},             1'b1, 8'h00, 1, 8'h00, {32'h0, 32'h0, 32'h0, 32'hD000_0020},                           3, 5, 1};
        vecs[2] = '{4'b0000, 8'h5A, {30'h33, 30'h32, 30'h31, 30'h30},             1'b1, 8'h00, 0, 8'h00, 128'h0,                                                         2, 0, 0};
        vecs[3] = '{4'b1111, 8'hC3, {30'h103, 30'h102, 30'h101, 30'h100},         1'b1, 8'h00, 4, 8'hE4, {32'hD000_0103, 32'hD000_0102, 32'hD000_0101, 32'hD000_0100}, 6, 0, 1};
        vecs[4] = '{4'b0100, 8'h77, {30'h43, 30'h2AAA_AAAA, 30'h41, 30'h40},      1'b0, 8'h02, 1, 8'h02, {32'h0, 32'hFAAA_AAAA, 32'h0, 32'h0},                           3, 0, 1};

        rst_n = 1'b0;
        lsu_req_valid = 1'b0; lsu_req_rw = 1'b0; lsu_req_mask = '0; lsu_req_byteen = '0;
        lsu_req_addr = '0; lsu_req_data = '0; lsu_req_tag = '0; lsu_rsp_ready = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
        #1;
        chk("reset handshakes", 128'({lsu_req_ready, lsu_rsp_valid, mem_req_valid, mem_rsp_ready}), 128'(4'b1000));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) do_txn(vecs[i], $sformatf("rd%0d", i));

        // write: all lanes, memory ready toggling every cycle
        @(negedge clk);
        clear_logs();
        stream_mode = 1'b1; gate = 0; rdy_mode = 1'b1;
        lsu_req_valid  = 1'b1;
        lsu_req_rw     = 1'b1;
        lsu_req_mask   = 4'b1111;
        lsu_req_byteen = {4'h1, 4'hC, 4'h3, 4'hF};
        lsu_req_addr   = {30'h203, 30'h202, 30'h201, 30'h200};
        lsu_req_data   = {32'hDDDD_4444, 32'hCCCC_3333, 32'hBBBB_2222, 32'hAAAA_1111};
        lsu_req_tag    = 8'h99;
        @(negedge clk);
        lsu_req_valid = 1'b0;
        done = 1'b0; saw_rsp = 1'b0; k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (lsu_rsp_valid) saw_rsp = 1'b1;
`ifdef LSU_BRIDGE_WR_ACK_EN
            done = lsu_rsp_valid;
`else
            done = (beat_tag.size() == 4) && lsu_req_ready;
`endif
        end
        chk("wr done", 128'(done), 128'(1));
        chk("wr beats", 128'(beat_tag.size()), 128'(4));
        for (int i = 0; i < beat_tag.size() && i < 4; i++) begin
            chk($sformatf("wr beat%0d", i),
                128'({beat_rw[i], beat_tag[i], beat_addr[i], beat_be[i], beat_data[i]}),
                128'({1'b1, 2'(i), lsu_req_addr[30*i +: 30], lsu_req_byteen[4*i +: 4], lsu_req_data[32*i +: 32]}));
        end
`ifdef LSU_BRIDGE_WR_ACK_EN
        chk("wr ack", {lsu_rsp_data[119:0], lsu_rsp_mask, lsu_rsp_tag}, {120'h0, 4'hF, 8'h99});
        lsu_rsp_ready = 1'b1;
        @(negedge clk);
        lsu_rsp_ready = 1'b0;
        chk("wr ack idle", 128'({lsu_req_ready, lsu_rsp_valid}), 128'(2'b10));
`else
        repeat (3) begin
            @(negedge clk);
            if (lsu_rsp_valid) saw_rsp = 1'b1;
        end
        chk("wr no rsp", 128'(saw_rsp), 128'(0));
`endif
        rdy_mode = 1'b0;

        // reset while two reads are outstanding
        @(negedge clk);
        clear_logs();
        stream_mode = 1'b0; gate = 99;
        lsu_req_valid = 1'b1; lsu_req_rw = 1'b0; lsu_req_mask = 4'b0011;
        lsu_req_byteen = '0; lsu_req_data = '0; lsu_req_tag = 8'h42;
        lsu_req_addr = {30'h303, 30'h302, 30'h301, 30'h300};
        @(negedge clk);
        lsu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst wait", 128'({mem_rsp_ready, mem_req_valid, lsu_req_ready}), 128'(3'b100));
        chk("pre_rst beats", 128'(beat_tag.size()), 128'(2));
        rst_n = 1'b0;
        #1;
        chk("rst handshakes", 128'({lsu_req_ready, lsu_rsp_valid, mem_req_valid, mem_rsp_ready}), 128'(4'b1000));
        chk("rst mem fields", 128'({mem_req_rw, mem_req_tag, mem_req_addr, mem_req_byteen, mem_req_data}), 128'(0));
        chk("rst lsu fields", {lsu_rsp_data[115:0], lsu_rsp_mask, lsu_rsp_tag}, 128'(0));
        @(negedge clk);
        clear_logs();
        gate = 0;
        rst_n = 1'b1;
        v = vecs[4];
        do_txn(v, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
